// File: rtl/manchester_encoder.sv
// Manchester line encoder: frames bytes as preamble -> MSB-first data -> idle gap on one wire.
// Latency: byte accepted at cycle N -> PREAMBLE state at N+1 -> first half-bit on the line at N+2.
// Backpressure: tx_ready_o drops while the one-byte holding register is full; enable_i=0 freezes the line.
//
// Ports:
//   clock_i, reset_n_i       clock and asynchronous active-low reset
//   enable_i                 0 freezes FSM, counters and line level; the byte handshake still works
//   tx_data_i/_valid_i/_last_i, tx_ready_o   byte input handshake (last marks the final byte of a frame)
//   manchester_out_o         registered Manchester line (bit 1 = low then high), idles low
//   tx_active_o              high during PREAMBLE, DATA and GAP
//   bit_strobe_o             one-cycle pulse, aligned with the first half of every preamble/data bit
//   underrun_o               one-cycle pulse when a frame aborts because no byte is ready at a byte boundary
module manchester_encoder #(
    parameter int         HALF_BIT_CYCLES = 4,
    parameter logic [7:0] PREAMBLE        = 8'hAA,
    parameter int         PREAMBLE_BITS   = 8,
    parameter int         GAP_BITS        = 4
) (
    input  logic       clock_i,
    input  logic       reset_n_i,
    input  logic       enable_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    input  logic       tx_last_i,
    output logic       tx_ready_o,
    output logic       manchester_out_o,
    output logic       tx_active_o,
    output logic       bit_strobe_o,
    output logic       underrun_o
);

    localparam int HCW = (HALF_BIT_CYCLES > 1) ? $clog2(HALF_BIT_CYCLES) : 1;
    localparam int BCW = ($clog2(GAP_BITS + 1) > 4) ? $clog2(GAP_BITS + 1) : 4;
    localparam logic [HCW-1:0] HALF_MAX  = HCW'(HALF_BIT_CYCLES - 1);
    localparam logic [BCW-1:0] PRE_LAST  = BCW'(PREAMBLE_BITS - 1);
    localparam logic [BCW-1:0] GAP_LAST  = BCW'(GAP_BITS - 1);
    localparam logic [BCW-1:0] DATA_LAST = BCW'(7);

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_GAP} state_t;

    state_t         state_q, state_d;
    logic [HCW-1:0] half_cnt_q, half_cnt_d;
    logic           phase_q, phase_d;
    logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           last_q, last_d;
    logic [7:0]     hold_dat_q, hold_dat_d;
    logic           hold_last_q, hold_last_d;
    logic           hold_full_q, hold_full_d;
    logic           line_q, line_d;
    logic           strobe_q, strobe_d;
    logic           underrun_q, underrun_d;

    logic load;       // shift register takes the holding byte this cycle
    logic accept;
    logic bit_end;
    logic bit_start;
    logic pre_bit;

    // Preamble is sent MSB first, so bit_cnt selects from the top down.
    assign pre_bit   = |(PREAMBLE & (8'h80 >> bit_cnt_q[2:0]));
    assign bit_end   = (half_cnt_q == HALF_MAX) && phase_q;
    assign bit_start = (half_cnt_q == '0) && !phase_q;

    always_comb begin
        state_d    = state_q;
        half_cnt_d = half_cnt_q;
        phase_d    = phase_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        last_d     = last_q;
        line_d     = line_q;
        strobe_d   = 1'b0;
        underrun_d = 1'b0;
        load       = 1'b0;
        if (enable_i) begin
            line_d = 1'b0;
            if (state_q != S_IDLE) begin
                if (half_cnt_q == HALF_MAX) begin
                    half_cnt_d = '0;
                    phase_d    = ~phase_q;
                end else begin
                    half_cnt_d = half_cnt_q + 1'b1;
                end
            end
            case (state_q)
                S_IDLE: begin
                    // In IDLE the holding register is either full or ready, so a valid byte
                    // is being accepted this very cycle; starting now saves a cycle of latency.
                    if (hold_full_q || tx_valid_i) begin
                        state_d    = S_PRE;
                        bit_cnt_d  = '0;
                        half_cnt_d = '0;
                        phase_d    = 1'b0;
                    end
                end
                S_PRE: begin
                    line_d   = ~(pre_bit ^ phase_q);
                    strobe_d = bit_start;
                    if (bit_end) begin
                        if (bit_cnt_q == PRE_LAST) begin
                            bit_cnt_d = '0;
                            if (hold_full_q) begin
                                load    = 1'b1;
                                state_d = S_DATA;
                            end else begin
                                underrun_d = 1'b1;
                                state_d    = S_GAP;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    line_d   = ~(shift_q[7] ^ phase_q);
                    strobe_d = bit_start;
                    if (bit_end) begin
                        shift_d = shift_q << 1;
                        if (bit_cnt_q == DATA_LAST) begin
                            bit_cnt_d = '0;
                            if (last_q) begin
                                state_d = S_GAP;
                            end else if (hold_full_q) begin
                                load = 1'b1;
                            end else begin
                                underrun_d = 1'b1;
                                state_d    = S_GAP;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (bit_end) begin
                        if (bit_cnt_q == GAP_LAST) begin
                            bit_cnt_d = '0;
                            state_d   = S_IDLE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
            if (load) begin
                shift_d = hold_dat_q;
                last_d  = hold_last_q;
            end
        end
    end

    // Holding register: a load empties it and a same-cycle accept refills it.
    assign tx_ready_o = ~hold_full_q | load;
    assign accept     = tx_valid_i && tx_ready_o;

    always_comb begin
        hold_full_d = hold_full_q;
        hold_dat_d  = hold_dat_q;
        hold_last_d = hold_last_q;
        if (load) begin
            hold_full_d = 1'b0;
        end
        if (accept) begin
            hold_full_d = 1'b1;
            hold_dat_d  = tx_data_i;
            hold_last_d = tx_last_i;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= S_IDLE;
            half_cnt_q  <= '0;
            phase_q     <= 1'b0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            last_q      <= 1'b0;
            hold_dat_q  <= '0;
            hold_last_q <= 1'b0;
            hold_full_q <= 1'b0;
            line_q      <= 1'b0;
            strobe_q    <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            half_cnt_q  <= half_cnt_d;
            phase_q     <= phase_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            last_q      <= last_d;
            hold_dat_q  <= hold_dat_d;
            hold_last_q <= hold_last_d;
            hold_full_q <= hold_full_d;
            line_q      <= line_d;
            strobe_q    <= strobe_d;
            underrun_q  <= underrun_d;
        end
    end

    assign manchester_out_o = line_q;
    assign tx_active_o      = (state_q != S_IDLE);
    assign bit_strobe_o     = strobe_q;
    assign underrun_o       = underrun_q;

endmodule
